apb_master_arbiter: RTL
=======================

// Module: apb_master_arbiter
// PURPOSE
//  APB master that shares one APB slave port (psel/pen/pwrite/paddr/pwdata) between
//  NUM_REQ local requesters. Arbitration is round-robin. Each transfer is sequenced
//  through the APB SETUP and ACCESS phases, with a pready wait and a timeout.
//  Sits between on-chip clients (config engines, test sequencers) and apb_slave.
// PARAMETERS
//  NUM_REQ     4    number of requesters (2..8)
//  ADDR_W      32   address width
//  DATA_W      32   data width
//  TIMEOUT     16   max ACCESS cycles waiting for pready before error (>=2)
// PORTS
//  pclk        in   1               clock, rising edge
//  prst        in   1               asynchronous, active-high reset
//  req         in   NUM_REQ         per-requester request, level
//  req_write   in   NUM_REQ         1=write, 0=read
//  req_addr    in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata   in   NUM_REQ*DATA_W  packed write data
//  gnt         out  NUM_REQ         one-hot, 1-cycle pulse when request captured (SETUP entry)
//  done        out  NUM_REQ         one-hot, 1-cycle pulse on transfer completion
//  rsp_rdata   out  DATA_W          read data, valid with done
//  rsp_err     out  1               timeout flag, valid with done
//  psel        out  1               APB select
//  pen         out  1               APB enable
//  pwrite      out  1               APB direction
//  paddr       out  ADDR_W          APB address
//  pwdata      out  DATA_W          APB write data
//  i_pready    in   1               APB ready from slave
//  i_prdata    in   DATA_W          APB read data from slave
// BEHAVIOUR
//  - Reset (async, any state) forces all of the following to 0:
//    gnt, done, rsp_rdata, rsp_err, psel, pen, pwrite, paddr, pwdata;
//    FSM=IDLE, rr pointer=0, timeout counter=0.
//  - FSM states:
//    IDLE: psel=0, pen=0. Moves to SETUP when any req is set.
//    SETUP: exactly 1 cycle. psel=1, pen=0, paddr/pwdata/pwrite registered from the
//      winner. Always moves to ACCESS.
//    ACCESS: psel=1, pen=1. Leaves when i_pready=1 or the counter reaches TIMEOUT-1.
//  - Arbitration at IDLE->SETUP and ACCESS->SETUP: round-robin starting at the rr pointer.
//    After a grant, pointer = winner+1 mod NUM_REQ. The winner's cmd is latched.
//  - Requester holds req and its fields stable until its done. It deasserts req in the
//    cycle after done unless it wants another transfer.
//  - Completion (ACCESS with i_pready=1):
//    done[winner]=1 for the next cycle; rsp_rdata=i_prdata on reads (unchanged on writes);
//    rsp_err=0.
//  - Timeout (TIMEOUT ACCESS cycles without pready): done pulses, rsp_err=1,
//    rsp_rdata=0; bus is released.
//  - Back-to-back: on completion, if another req (excluding the finishing winner) is
//    pending, go ACCESS->SETUP directly. psel stays 1, pen drops for the SETUP cycle.
//    Otherwise go to IDLE.
//  - Latency: req set in IDLE -> gnt at +1 -> earliest done at +3 (zero-wait slave).
//  - APB outputs are stable through the whole SETUP+ACCESS of one transfer.
//    paddr, pwdata and pwrite hold their last value in IDLE.
//  - Timeout counter clears on SETUP entry. It is ADDR-independent, width $clog2(TIMEOUT).
//  - Reset mid-ACCESS: bus drops immediately (async), and no done is issued for the
//    aborted transfer.
// STRUCTURE
//  - apb_pkg: typedef enum logic[1:0] {IDLE,SETUP,ACCESS} apb_state_e;
//    localparam defaults for ADDR_W and DATA_W.
//  - Sub-module rr_arbiter #(N): inputs req and ptr, output one-hot grant. Combinational.
//    Pointer register stays in the top.
//  - Top: FSM, command latch, timeout counter, response registers.
// TESTING
//  1. Single write: req[0] with addr=0x04, wdata=0xA5A5_0001, i_pready tied 1
//     -> psel 1 cycle then psel+pen 1 cycle; done[0] at cycle 3; rsp_err=0.
//  2. Read with 2 wait states: req[1] read addr=0x08, slave raises pready after 2 pen
//     cycles with prdata=0xDEAD_BEEF -> rsp_rdata=0xDEAD_BEEF with done[1].
//  3. Contention: req=4'b1111 held -> grant order 0,1,2,3,0. No gap: pen low for exactly
//     1 cycle between transfers, psel never drops.
//  4. Timeout: TIMEOUT=16, pready held 0 -> done[0] with rsp_err=1 after 16 pen cycles,
//     rsp_rdata=0, then FSM returns to IDLE.
//  5. Reset mid-ACCESS: assert prst during pen -> psel/pen/gnt/done go 0 the same cycle,
//     no done. After release, a new req[2] gets granted first (pointer back at 0,
//     none lower pending).
//  6. Against apb_slave: write 0x1234 to addr 3, then read addr 3 -> rsp_rdata=0x1234.

Source files
------------

// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and defaults for the APB master arbiter.
//   apb_state_e   : bus sequencing states (idle, setup, access)
//   DefaultAddrW  : default address width
//   DefaultDataW  : default data width
//   idx_w()       : width of an index into n items (at least 1 bit)
package apb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultDataW = 32;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : N request lines
//   ptr   : highest-priority index for this decision
//   grant : one-hot winner, first set req scanning ptr, ptr+1, ... (mod N); zero if no req
module apb_master_arbiter_rr_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          grant
);

  localparam int unsigned PtrW = idx_w(N);
  localparam int unsigned SumW = PtrW + 1;

  logic            found;
  logic [SumW-1:0] pos;
  logic [PtrW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr + i wrapped into 0..N-1 without a divider
      pos = {1'b0, ptr} + SumW'(i);
      if (pos >= SumW'(N)) begin
        pos = pos - SumW'(N);
      end
      idx = pos[PtrW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared round-robin between NUM_REQ local requesters.
//   pclk, prst           : clock (rising edge), asynchronous active-high reset
//   req/req_write        : per-requester level request and direction (1 = write)
//   req_addr/req_wdata   : packed per-requester command, requester i at [i*W +: W]
//   gnt                  : one-hot pulse in the SETUP cycle of the captured command
//   done                 : one-hot pulse the cycle after a transfer ends
//   rsp_rdata/rsp_err    : response, valid with done (rsp_err = timed out)
//   psel/pen/pwrite/paddr/pwdata, i_pready/i_prdata : APB master port
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        pclk,
  input  logic                        prst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        psel,
  output logic                        pen,
  output logic                        pwrite,
  output logic [ADDR_W-1:0]           paddr,
  output logic [DATA_W-1:0]           pwdata,
  input  logic                        i_pready,
  input  logic [DATA_W-1:0]           i_prdata
);

  localparam int unsigned PtrW = idx_w(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  apb_state_e         state_q;
  logic [PtrW-1:0]    ptr_q;
  logic [NUM_REQ-1:0] cur_q;    // one-hot owner of the transfer in flight
  logic [CntW-1:0]    cnt_q;

  logic [NUM_REQ-1:0] excl;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               any_win;
  logic               timed_out;
  logic               launch;
  logic               win_write;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic [PtrW-1:0]    win_next_ptr;

  // A requester still holds req while its transfer finishes and during its done
  // pulse; mask it so a served request is never granted twice.
  assign excl    = (state_q == StAccess) ? cur_q : done;
  assign arb_req = req & ~excl;

  apb_master_arbiter_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req   (arb_req),
    .ptr   (ptr_q),
    .grant (arb_gnt)
  );

  assign any_win   = |arb_gnt;
  assign timed_out = (cnt_q == CntLast);
  assign launch    = any_win &&
                     ((state_q == StIdle) || ((state_q == StAccess) && i_pready));

  always_comb begin
    win_write    = 1'b0;
    win_addr     = '0;
    win_wdata    = '0;
    win_next_ptr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_write    = req_write[i];
        win_addr     = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata    = req_wdata[i*DATA_W +: DATA_W];
        win_next_ptr = (i == NUM_REQ - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      pen       <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state_q)
        StIdle: begin
          psel <= 1'b0;
          pen  <= 1'b0;
        end
        StSetup: begin
          pen     <= 1'b1;
          state_q <= StAccess;
        end
        StAccess: begin
          if (i_pready || timed_out) begin
            done <= cur_q;
            if (i_pready) begin
              rsp_err <= 1'b0;
              if (!pwrite) begin
                rsp_rdata <= i_prdata;
              end
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
            // Release the bus; overridden below when a back-to-back grant follows.
            state_q <= StIdle;
            psel    <= 1'b0;
            pen     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          psel    <= 1'b0;
          pen     <= 1'b0;
        end
      endcase

      if (launch) begin
        state_q <= StSetup;
        psel    <= 1'b1;
        pen     <= 1'b0;
        pwrite  <= win_write;
        paddr   <= win_addr;
        pwdata  <= win_wdata;
        gnt     <= arb_gnt;
        cur_q   <= arb_gnt;
        ptr_q   <= win_next_ptr;
        cnt_q   <= '0;
      end
    end
  end

endmodule
